// File: rtl/fadd_lane_sequencer.sv
// fadd_lane_sequencer: streams a vector of lane operand pairs through one external
// combinational float adder, one lane per cycle, and collects the sums and flags.
// Ports: clk, rst (async, active-high); in_valid/in_ready + vec_a, vec_b, exec_mask
// accept a vector; add_a/add_b drive the adder, add_out/add_nan/add_ovf return from
// it; out_valid/out_ready + vec_out, nan_mask, ovf_any, nan_any present the result.
// Optional macro FADD_SEQ_SKIP_EN: visit only active lanes (exec_mask=0 goes straight
// to DONE); otherwise every lane is stepped for a fixed LANES+1 edge latency.
module fadd_lane_sequencer #(
  parameter int LANES = 32,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] vec_a,
  input  logic [LANES*WIDTH-1:0] vec_b,
  input  logic [LANES-1:0]       exec_mask,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [WIDTH-1:0]       add_out,
  input  logic                   add_nan,
  input  logic                   add_ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] vec_out,
  output logic [LANES-1:0]       nan_mask,
  output logic                   ovf_any,
  output logic                   nan_any
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [LANES*WIDTH-1:0] a_q, a_d, b_q, b_d, vec_out_q, vec_out_d;
  logic [LANES-1:0]       mask_q, mask_d, nan_mask_q, nan_mask_d;
  logic                   nan_any_q, nan_any_d, ovf_any_q, ovf_any_d;
`ifdef FADD_SEQ_SKIP_EN
  logic          hit;
  logic [IW-1:0] nxt;
  // {found, index} of the lowest set mask bit at or above position s
  function automatic logic [IW:0] first_from(input logic [LANES-1:0] m, input int s);
    first_from = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (i >= s && m[i]) first_from = {1'b1, IW'(i)};
  endfunction
`endif
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign add_a     = state_q == RUN ? a_q[idx_q*WIDTH +: WIDTH] : '0;
  assign add_b     = state_q == RUN ? b_q[idx_q*WIDTH +: WIDTH] : '0;
  assign vec_out   = vec_out_q;
  assign nan_mask  = nan_mask_q;
  assign nan_any   = nan_any_q;
  assign ovf_any   = ovf_any_q;
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    mask_d     = mask_q;
    vec_out_d  = vec_out_q;
    nan_mask_d = nan_mask_q;
    nan_any_d  = nan_any_q;
    ovf_any_d  = ovf_any_q;
`ifdef FADD_SEQ_SKIP_EN
    hit        = 1'b0;
    nxt        = '0;
`endif
    if (state_q == IDLE && in_valid) begin
      a_d        = vec_a;
      b_d        = vec_b;
      mask_d     = exec_mask;
      vec_out_d  = '0;
      nan_mask_d = '0;
      nan_any_d  = 1'b0;
      ovf_any_d  = 1'b0;
`ifdef FADD_SEQ_SKIP_EN
      {hit, nxt} = first_from(exec_mask, 0);
      idx_d      = nxt;
      state_d    = hit ? RUN : DONE;
`else
      idx_d      = '0;
      state_d    = RUN;
`endif
    end else if (state_q == RUN) begin
      if (mask_q[idx_q]) begin
        vec_out_d[idx_q*WIDTH +: WIDTH] = add_out;
        nan_mask_d[idx_q] = add_nan;
        nan_any_d = nan_any_q | add_nan;
        ovf_any_d = ovf_any_q | add_ovf;
      end
`ifdef FADD_SEQ_SKIP_EN
      {hit, nxt} = first_from(mask_q, int'(idx_q) + 1);
      idx_d      = hit ? nxt : idx_q;
      state_d    = hit ? RUN : DONE;
`else
      idx_d   = idx_q == IW'(LANES - 1) ? idx_q : idx_q + 1'b1;
      state_d = idx_q == IW'(LANES - 1) ? DONE : RUN;
`endif
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mask_q     <= '0;
      vec_out_q  <= '0;
      nan_mask_q <= '0;
      nan_any_q  <= 1'b0;
      ovf_any_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mask_q     <= mask_d;
      vec_out_q  <= vec_out_d;
      nan_mask_q <= nan_mask_d;
      nan_any_q  <= nan_any_d;
      ovf_any_q  <= ovf_any_d;
    end
  end
endmodule

// File: tb/tb_fadd_lane_sequencer.sv
// tb_fadd_lane_sequencer: directed bench with a queue-based reference model of the
// lane sequencer and a stub float adder that reproduces the documented vectors.
module tb_fadd_lane_sequencer;
  localparam int L = 32, W = 32;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [L*W-1:0] vec_a = '0, vec_b = '0, vec_out;
  logic [L-1:0]   exec_mask = '0, nan_mask;
  logic [W-1:0]   add_a, add_b, add_out;
  logic           add_nan, add_ovf, in_ready, out_valid, ovf_any, nan_any;
  int pass_cnt = 0, total_cnt = 0, lat;
  fadd_lane_sequencer #(.LANES(L), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .vec_a(vec_a), .vec_b(vec_b), .exec_mask(exec_mask),
    .add_a(add_a), .add_b(add_b), .add_out(add_out), .add_nan(add_nan), .add_ovf(add_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .vec_out(vec_out),
    .nan_mask(nan_mask), .ovf_any(ovf_any), .nan_any(nan_any));
  always #5 clk = ~clk;
  // stub adder: exact results for the documented vectors, an asymmetric mix otherwise
  function automatic logic [W+1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return {2'b00, 32'h40400000};
    if (a == 32'h7F800000 && b == 32'hFF800000) return {2'b10, 32'h7FC00000};
    if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {2'b01, 32'h7F800000};
    return {a[30] & b[29], a[28] & b[27], a + (b << 1)};
  endfunction
  assign {add_nan, add_ovf, add_out} = fadd(add_a, add_b);
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
  endtask
  // reference model: whole-vector results computed at accept, a queue of lanes to visit
  int q[$];
  int phase = 0;
  logic [W-1:0]   ma[L], mb[L];
  logic [L*W-1:0] e_out = '0;
  logic [L-1:0]   e_nan = '0;
  logic           e_nany = 0, e_ovf = 0;
  logic [W+1:0]   r;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase = 0;
      q.delete();
    end else if (phase == 0) begin
      if (in_valid) begin
        q.delete();
        e_out = '0; e_nan = '0; e_nany = 0; e_ovf = 0;
        for (int i = 0; i < L; i++) begin
          ma[i] = vec_a[i*W +: W];
          mb[i] = vec_b[i*W +: W];
          if (exec_mask[i]) begin
            r = fadd(ma[i], mb[i]);
            e_out[i*W +: W] = r[W-1:0];
            e_nan[i] = r[W+1];
            e_nany |= r[W+1];
            e_ovf |= r[W];
          end
`ifdef FADD_SEQ_SKIP_EN
          if (exec_mask[i]) q.push_back(i);
`else
          q.push_back(i);
`endif
        end
        phase = q.size() == 0 ? 2 : 1;
      end
    end else if (phase == 1) begin
      void'(q.pop_front());
      if (q.size() == 0) phase = 2;
    end else if (out_ready) phase = 0;
  end
  always @(negedge clk) begin
    #1;
    chk("in_ready", in_ready, phase == 0);
    chk("out_valid", out_valid, phase == 2);
    chk("add_a", add_a, phase == 1 ? ma[q[0]] : 0);
    chk("add_b", add_b, phase == 1 ? mb[q[0]] : 0);
    if (rst || phase == 2) begin
      for (int i = 0; i < L; i++)
        chk($sformatf("vec_out[%0d]", i), vec_out[i*W +: W], rst ? 0 : e_out[i*W +: W]);
      chk("nan_mask", nan_mask, rst ? 0 : e_nan);
      chk("nan_any", nan_any, rst ? 0 : e_nany);
      chk("ovf_any", ovf_any, rst ? 0 : e_ovf);
    end
  end
  function automatic logic [L*W-1:0] pat(input int s);
    for (int i = 0; i < L; i++) pat[i*W +: W] = 32'h9E3779B9 * (i + s * 37 + 1);
  endfunction
  function automatic logic [L*W-1:0] fill(input logic [W-1:0] v);
    for (int i = 0; i < L; i++) fill[i*W +: W] = v;
  endfunction
  task automatic start(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                       input logic [L-1:0] m, output int n);
    vec_a = a; vec_b = b; exec_mask = m; in_valid = 1;
    @(posedge clk); @(negedge clk);
    in_valid = 0; n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
  endtask
  task automatic finish(input int hold, input logic ov);
    repeat (hold) @(negedge clk);
    out_ready = 1; in_valid = ov;
    @(posedge clk); @(negedge clk);
    out_ready = 0; in_valid = 0;
    chk("idle_after_done", in_ready, 1);
    @(negedge clk);
    chk("no_accept_at_done", in_ready, 1);
  endtask
  logic [L*W-1:0] va, vb;
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_vec_out_lane0", vec_out[W-1:0], 0);
    rst = 0;
    @(negedge clk);
    start(fill(32'h3F800000), fill(32'h40000000), '1, lat);
    chk("lat_all_lanes", lat, 33);
    chk("sum_lane0", vec_out[W-1:0], 32'h40400000);
    chk("sum_lane31", vec_out[31*W +: W], 32'h40400000);
    chk("sum_flags", {nan_any, ovf_any}, 0);
    finish(0, 0);
    va = '0; vb = '0;
    va[5*W +: W] = 32'h7F800000; vb[5*W +: W] = 32'hFF800000;
    start(va, vb, '1, lat);
    chk("nan_mask_lit", nan_mask, 32'h00000020);
    chk("nan_any_lit", nan_any, 1);
    chk("nan_lane5", vec_out[5*W +: W], 32'h7FC00000);
    chk("nan_lane4", vec_out[4*W +: W], 0);
    finish(0, 0);
    va = pat(5); vb = pat(6);
    va[31*W +: W] = 32'h7F7FFFFF; vb[31*W +: W] = 32'h7F7FFFFF;
    start(va, vb, 32'h80000000, lat);
`ifdef FADD_SEQ_SKIP_EN
    chk("lat_one_lane", lat, 2);
`else
    chk("lat_one_lane", lat, 33);
`endif
    chk("ovf_any_lit", ovf_any, 1);
    chk("ovf_lanes_low_zero", vec_out[31*W-1:0] == '0, 1);
    finish(0, 0);
    start(pat(3), pat(4), '1, lat);
    chk("held_out_valid", out_valid, 1);
    finish(10, 1);
    out_ready = 1;
    start(pat(1), pat(2), 32'hA5A50F0F, lat);
    chk("partial_inactive_lane4", vec_out[4*W +: W], 0);
    finish(0, 0);
    vec_a = pat(7); vec_b = pat(8); exec_mask = '1; in_valid = 1;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1;
    #2;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_add_a", add_a, 0);
    @(negedge clk);
    rst = 0;
    #2;
    chk("ready_after_rst", in_ready, 1);
    start(fill(32'h3F800000), fill(32'h40000000), 32'h0000FFFF, lat);
    chk("fresh_lat", lat, `ifdef FADD_SEQ_SKIP_EN 17 `else 33 `endif);
    chk("fresh_flags", {nan_any, ovf_any, nan_mask}, 0);
    chk("fresh_lane3", vec_out[3*W +: W], 32'h40400000);
    chk("fresh_lane20", vec_out[20*W +: W], 0);
    finish(0, 0);
    start(pat(9), pat(10), '0, lat);
`ifdef FADD_SEQ_SKIP_EN
    chk("lat_empty_mask", lat, 1);
`else
    chk("lat_empty_mask", lat, 33);
`endif
    chk("empty_vec_out", vec_out == '0, 1);
    chk("empty_nan_mask", nan_mask, 0);
    finish(0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
